// File: rtl/decoder_scan_seq.sv
// Sequencer that sweeps the 2-to-4 decoder's Din through 00..11 with En high,
// holding each code for DWELL cycles; single-sweep or continuous operation.
module decoder_scan_seq #(
    parameter int unsigned DWELL = 100,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    output logic [1:0] Din,
    output logic       En,
    output logic       busy,
    output logic       done
);

    // A zero dwell degenerates to a one-cycle hold per code.
    localparam int unsigned DW = (DWELL == 0) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DW - 1);

    generate
        if (64'(DW) > ((64'(1) << CNT_W) - 64'(1))) begin : g_dwell_chk
            $error("decoder_scan_seq: DWELL does not fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       din_nxt;
    logic             en_nxt;
    logic             done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            Din   <= '0;
            En    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Din   <= din_nxt;
            En    <= en_nxt;
            busy  <= en_nxt;
            done  <= done_nxt;
        end
    end

    // Defaults describe the idle output pattern; only SCAN holds or advances.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        din_nxt   = 2'b00;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = SCAN;
                    en_nxt    = 1'b1;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    if (Din != 2'b11) begin
                        din_nxt = Din + 2'd1;
                        en_nxt  = 1'b1;
                    end else if (mode) begin
                        en_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    din_nxt = Din;
                    en_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: two instances (DWELL=4 and DWELL=1) share stimulus
// and are checked every cycle against a sweep-position model plus directed literals.
module tb_decoder_scan_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [1:0] din  [2];
    logic       en   [2];
    logic       busy [2];
    logic       done [2];

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    decoder_scan_seq #(.DWELL(4), .CNT_W(16)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .Din(din[0]), .En(en[0]), .busy(busy[0]), .done(done[0])
    );

    decoder_scan_seq #(.DWELL(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .Din(din[1]), .En(en[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int dw(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position k counts cycles since the sweep began; Din is k/DWELL.
    bit m_act [2];
    bit m_done[2];
    bit m_wrap[2];
    int m_k   [2];

    always @(posedge clk) begin : model
        bit a, d, w;
        int k;
        for (int i = 0; i < 2; i++) begin
            a = m_act[i]; d = 1'b0; w = 1'b0; k = m_k[i];
            if (rst) begin
                a = 1'b0; k = 0;
            end else if (m_done[i]) begin
                a = 1'b0;
            end else if (!a) begin
                if (start && !stop) begin a = 1'b1; k = 0; end
            end else if (stop) begin
                a = 1'b0; k = 0;
            end else begin
                k = k + 1;
                if (k == 4 * dw(i)) begin
                    k = 0;
                    if (mode) w = 1'b1;
                    else begin a = 1'b0; d = 1'b1; end
                end
            end
            m_act[i]  <= a;
            m_done[i] <= d;
            m_wrap[i] <= w;
            m_k[i]    <= k;
        end
    end

    int en_cnt[2] = '{0, 0};

    always @(negedge clk) begin : compare
        logic [1:0] ed;
        logic [3:0] do_v, do_e;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                ed   = m_act[i] ? 2'((m_k[i] / dw(i)) % 4) : 2'b00;
                do_v = en[i] ? (4'b0001 << din[i]) : 4'b0000;
                do_e = m_act[i] ? (4'b0001 << ed) : 4'b0000;
                check($sformatf("din[%0d]", i),  32'(din[i]),  32'(ed));
                check($sformatf("en[%0d]", i),   32'(en[i]),   32'(m_act[i]));
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_act[i]));
                check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
                check($sformatf("do[%0d]", i),   32'(do_v),    32'(do_e));
                check($sformatf("do_ones[%0d]", i), 32'($countones(do_v)), 32'(en[i]));
                if (m_wrap[i]) en_cnt[i] = en[i] ? 1 : 0;
                else if (en[i]) en_cnt[i] = en_cnt[i] + 1;
                if (m_done[i])
                    check($sformatf("en_cycles[%0d]", i), 32'(en_cnt[i]), 32'(4 * dw(i)));
                if (!m_act[i]) en_cnt[i] = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [1:0] t4 [16];

    initial begin
        t4 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
               2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            check("rst_din",  32'(din[i]),  32'd0);
            check("rst_en",   32'(en[i]),   32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
        end
        chk_on = 1'b1;
        rst = 1'b0; start = 1'b0;
        step();

        // Single sweep; start re-pulsed mid-scan and while in DONE.
        start = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            start = (e == 6 || e == 17);
            if (e <= 16) begin
                check("t2_din", 32'(din[0]), 32'(t4[e-1]));
                check("t2_en",  32'(en[0]),  32'd1);
            end else if (e == 17) begin
                check("t2_done17", 32'(done[0]), 32'd1);
                check("t2_en17",   32'(en[0]),   32'd0);
                check("t2_busy17", 32'(busy[0]), 32'd0);
            end else begin
                check("t2_done18", 32'(done[0]), 32'd0);
                check("t2_en18",   32'(en[0]),   32'd0);
            end
            if (e <= 4) begin
                check("t6_din", 32'(din[1]), 32'(e - 1));
                check("t6_en",  32'(en[1]),  32'd1);
            end else if (e == 5) begin
                check("t6_done", 32'(done[1]), 32'd1);
                check("t6_en5",  32'(en[1]),   32'd0);
            end
        end
        start = 1'b0;
        repeat (6) step();

        start = 1'b1; stop = 1'b1;
        step();
        check("t5_idle_en", 32'(en[0]), 32'd0);
        start = 1'b0; stop = 1'b0;
        step();

        // Stop during the second cycle of Din=10, then a clean restart.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("t4_din10", 32'(din[0]), 32'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stop_din",  32'(din[0]),  32'd0);
        check("t4_stop_en",   32'(en[0]),   32'd0);
        check("t4_stop_busy", 32'(busy[0]), 32'd0);
        check("t4_stop_done", 32'(done[0]), 32'd0);
        start = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            start = 1'b0;
            check("t4_restart_din", 32'(din[0]), (e <= 4) ? 32'd0 : 32'd1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Continuous: three full wraps, then stop.
        mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        check("t3_wrap_din", 32'(din[0]), 32'd0);
        check("t3_wrap_en",  32'(en[0]),  32'd1);
        repeat (32) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop_en",  32'(en[0]),  32'd0);
        check("t3_stop_din", 32'(din[0]), 32'd0);
        mode = 1'b0;
        step();

        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom % 500) == 0;
            start = ($urandom % 4) == 0;
            stop  = ($urandom % 40) == 0;
            if (($urandom % 20) == 0) mode = ~mode;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
